// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_NREGS = 32;
  localparam int unsigned DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, issue wins on collision.
module rf_scoreboard #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          busy1,
  output logic          busy2
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Next busy vector: clear first so a same-register issue overrides the writeback.
  always_comb begin
    busy_nxt = busy;
    if (clr_en)
      busy_nxt[clr_addr] = 1'b0;
    if (set_en && !(ZERO_REG && set_addr == '0))
      busy_nxt[set_addr] = 1'b1;
  end

  // Busy vector register, frozen while disabled.
  always_ff @(posedge clk) begin
    if (reset)
      busy <= '0;
    else if (en)
      busy <= busy_nxt;
  end

  // Lookups: a same-cycle writeback to the looked-up register is forwarded, so no hazard.
  always_comb begin
    busy1 = busy[rs1] & ~(clr_en && clr_addr == rs1);
    busy2 = busy[rs2] & ~(clr_en && clr_addr == rs2);
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with forwarding, optional zero register and busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = DEF_XLEN,
  parameter int unsigned NREGS    = DEF_NREGS,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            rd_en,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            rvalid,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            hazard
);

  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;
  logic            wr_ok;

  assign wr_ok = we && !(ZERO_REG && waddr == '0);

  // Read-port data: stored value, overridden by same-cycle write, forced to 0 for the zero register.
  always_comb begin
    fwd1 = rf[rs1];
    fwd2 = rf[rs2];
    if (we && waddr == rs1) fwd1 = wdata;
    if (we && waddr == rs2) fwd2 = wdata;
    if (ZERO_REG && rs1 == '0) fwd1 = '0;
    if (ZERO_REG && rs2 == '0) fwd2 = '0;
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (reset)
      rf <= '{default: '0};
    else if (en && wr_ok)
      rf[waddr] <= wdata;
  end

  // Registered read data and valid pulse; data holds when no read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata1 <= '0;
      rdata2 <= '0;
      rvalid <= 1'b0;
    end else if (en) begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata1 <= fwd1;
        rdata2 <= fwd2;
      end
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .set_en   (issue_en),
    .set_addr (issue_rd),
    .clr_en   (we),
    .clr_addr (waddr),
    .rs1      (rs1),
    .rs2      (rs2),
    .busy1    (busy1),
    .busy2    (busy2)
  );

  // Advisory stall request for decode.
  always_comb hazard = rd_en & (busy1 | busy2);

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed check of regfile_sb against an array-based reference model.
module tb_regfile_sb;

  logic        clk;
  logic        reset, en, rd_en, we, issue_en;
  logic [4:0]  rs1, rs2, waddr, issue_rd;
  logic [31:0] wdata, rdata1, rdata2;
  logic        rvalid, busy1, busy2, hazard;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // reference model state
  logic [31:0] m_rf   [32];
  logic        m_busy [32];
  logic [31:0] m_rd1, m_rd2;
  logic        m_rvalid;

  regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .rd_en(rd_en), .rs1(rs1), .rs2(rs2),
    .rdata1(rdata1), .rdata2(rdata2), .rvalid(rvalid),
    .we(we), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .busy1(busy1), .busy2(busy2), .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return m_rf[a];
  endfunction

  function automatic logic model_busy(input logic [4:0] a);
    return m_busy[a] && !(we && waddr == a);
  endfunction

  // Drive one cycle of inputs, check combinational outputs, clock, update model, check registers.
  task automatic step(input logic r, input logic e, input logic re, input logic [4:0] a1,
                      input logic [4:0] a2, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic ie, input logic [4:0] ir);
    logic b1, b2;
    reset = r; en = e; rd_en = re; rs1 = a1; rs2 = a2;
    we = w; waddr = wa; wdata = wd; issue_en = ie; issue_rd = ir;
    #1;
    b1 = model_busy(a1);
    b2 = model_busy(a2);
    check("busy1", {31'b0, busy1}, {31'b0, b1});
    check("busy2", {31'b0, busy2}, {31'b0, b2});
    check("hazard", {31'b0, hazard}, {31'b0, re & (b1 | b2)});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_busy[i] = 1'b0; end
      m_rd1 = '0; m_rd2 = '0; m_rvalid = 1'b0;
    end else if (e) begin
      m_rvalid = re;
      if (re) begin m_rd1 = model_read(a1); m_rd2 = model_read(a2); end
      if (w && wa != 5'd0) m_rf[wa] = wd;
      if (w) m_busy[wa] = 1'b0;
      if (ie && ir != 5'd0) m_busy[ir] = 1'b1;
    end
    #1;
    check("rdata1", rdata1, m_rd1);
    check("rdata2", rdata2, m_rd2);
    check("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; en = 1; rd_en = 0; rs1 = 0; rs2 = 0; we = 0; waddr = 0; wdata = 0;
    issue_en = 0; issue_rd = 0;
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_busy[i] = 1'b0; end
    m_rd1 = '0; m_rd2 = '0; m_rvalid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_rvalid", {31'b0, rvalid}, 32'h0);
    check("reset_rdata1", rdata1, 32'h0);

    // 1. reset clears written register
    step(0, 1, 0, 0, 0, 1, 5, 32'hDEAD, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    check("t1_rdata1", rdata1, 32'h0);
    check("t1_rvalid", {31'b0, rvalid}, 32'h1);

    // 2. basic write then read
    step(0, 1, 0, 0, 0, 1, 3, 32'h1234_5678, 0, 0);
    step(0, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    check("t2_rdata1", rdata1, 32'h1234_5678);
    check("t2_rdata2", rdata2, 32'h0);
    idle();
    check("t2_rvalid_drop", {31'b0, rvalid}, 32'h0);
    check("t2_rdata_hold", rdata1, 32'h1234_5678);

    // 3. same-cycle forwarding
    step(0, 1, 1, 7, 3, 1, 7, 32'hA5A5_A5A5, 0, 0);
    check("t3_fwd", rdata1, 32'hA5A5_A5A5);

    // 4. zero register ignores writes and issue
    step(0, 1, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("t4_zero", rdata1, 32'h0);
    check("t4_busy0", {31'b0, busy1}, 32'h0);

    // 5. scoreboard set, forwarded clear, issue-wins collision
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, 9);
    rd_en = 1; rs1 = 9; #1;
    check("t5_busy", {31'b0, busy1}, 32'h1);
    check("t5_hazard", {31'b0, hazard}, 32'h1);
    step(0, 1, 1, 9, 0, 1, 9, 32'h0BAD_F00D, 0, 0);
    check("t5_fwd", rdata1, 32'h0BAD_F00D);
    step(0, 1, 0, 0, 0, 1, 9, 32'h1, 1, 9);
    step(0, 1, 1, 9, 0, 0, 0, 0, 0, 0);
    check("t5_issue_wins", {31'b0, busy1}, 32'h1);

    // 6. enable freezes state; reset beats enable
    step(0, 0, 1, 3, 9, 1, 3, 32'h5555_5555, 1, 4);
    check("t6_hold_rvalid", {31'b0, rvalid}, 32'h1);
    step(0, 1, 1, 3, 4, 0, 0, 0, 0, 0);
    check("t6_no_write", rdata1, 32'h1234_5678);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_reset_rvalid", {31'b0, rvalid}, 32'h0);
    step(0, 1, 1, 9, 3, 0, 0, 0, 0, 0);
    check("t6_reset_busy", {31'b0, busy1}, 32'h0);

    // randomized traffic, addresses biased to a small window for collisions
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] a1, a2, wa, ir;
      a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      ir = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), 1'($urandom),
           a1, a2, 1'($urandom), wa, $urandom, 1'($urandom), ir);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time limit so the run always terminates
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
